// File: rtl/fp_result_buffer.sv
// Result buffer: a first-word-fall-through FIFO that stores each product with its IEEE-754 class flags.
// A push is visible at the head one cycle later. in_ready falls when the FIFO is full. Saturating statistics counters.
module fp_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_data,
  output logic                       out_sign,
  output logic                       out_zero,
  output logic                       out_denorm,
  output logic                       out_inf,
  output logic                       out_nan,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_cnt,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [CNT_W-1:0]           special_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          enable;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  logic [7:0]    in_exp;
  logic [22:0]   in_man;
  logic          c_zero;
  logic          c_denorm;
  logic          c_inf;
  logic          c_nan;
  logic          c_special;

  // Each entry holds {sign, zero, denorm, inf, nan, data}.
  logic [36:0]   mem [DEPTH];
  logic [36:0]   head;

  assign in_ready  = enable && (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign in_exp    = in_data[30:23];
  assign in_man    = in_data[22:0];
  assign c_zero    = (in_exp == 8'h00) && (in_man == '0);
  assign c_denorm  = (in_exp == 8'h00) && (in_man != '0);
  assign c_inf     = (in_exp == 8'hFF) && (in_man == '0);
  assign c_nan     = (in_exp == 8'hFF) && (in_man != '0);
  assign c_special = c_inf || c_nan;

  // Holds in_ready low for one cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable <= 1'b0;
    end else begin
      enable <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read once level covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_data[31], c_zero, c_denorm, c_inf, c_nan, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Clear wins over a coincident increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_cnt   <= '0;
      special_cnt <= '0;
    end else if (clr_cnt) begin
      total_cnt   <= '0;
      special_cnt <= '0;
    end else if (push) begin
      if (!(&total_cnt)) begin
        total_cnt <= total_cnt + CNT_W'(1);
      end
      if (c_special && !(&special_cnt)) begin
        special_cnt <= special_cnt + CNT_W'(1);
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign out_data   = head[31:0];
  assign out_nan    = head[32];
  assign out_inf    = head[33];
  assign out_denorm = head[34];
  assign out_zero   = head[35];
  assign out_sign   = head[36];

endmodule

// File: tb/tb_fp_result_buffer.sv
// Bench for fp_result_buffer: a queue-based model checked every cycle, plus directed literal checks.
// A second instance with 2-bit counters exercises counter saturation.
module tb_fp_result_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic             in_ready, out_valid, out_sign, out_zero, out_denorm, out_inf, out_nan;
  logic [31:0]      out_data;
  logic [2:0]       level;
  logic [CNT_W-1:0] total_cnt, special_cnt;

  logic             s_in_ready, s_out_valid, s_sign, s_zero, s_denorm, s_inf, s_nan;
  logic [31:0]      s_out_data;
  logic [2:0]       s_level;
  logic [SAT_W-1:0] s_total_cnt, s_special_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sign(out_sign), .out_zero(out_zero),
    .out_denorm(out_denorm), .out_inf(out_inf), .out_nan(out_nan), .out_ready(out_ready),
    .level(level), .clr_cnt(clr_cnt), .total_cnt(total_cnt), .special_cnt(special_cnt)
  );

  fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_sign(s_sign), .out_zero(s_zero),
    .out_denorm(s_denorm), .out_inf(s_inf), .out_nan(s_nan), .out_ready(out_ready),
    .level(s_level), .clr_cnt(clr_cnt), .total_cnt(s_total_cnt), .special_cnt(s_special_cnt)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] mq[$];
  bit m_en = 1'b0;
  bit m_pushed = 1'b0;
  int m_total = 0, m_special = 0, m_total2 = 0, m_special2 = 0;

  function automatic int sat_inc(input int v, input int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  function automatic bit is_special(input logic [31:0] w);
    return w[30:23] == 8'hFF;
  endfunction

  // {sign, zero, denorm, inf, nan}
  function automatic logic [4:0] flags_of(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    return {w[31], e == 8'h00 && m == 0, e == 8'h00 && m != 0,
            e == 8'hFF && m == 0, e == 8'hFF && m != 0};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_en = 1'b0;
      m_pushed = 1'b0;
      m_total = 0; m_special = 0; m_total2 = 0; m_special2 = 0;
    end else begin
      bit ir, pu, po;
      ir = m_en && (mq.size() < DEPTH);
      pu = in_valid && ir;
      po = (mq.size() > 0) && out_ready;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(in_data);
      if (clr_cnt) begin
        m_total = 0; m_special = 0; m_total2 = 0; m_special2 = 0;
      end else if (pu) begin
        m_total  = sat_inc(m_total, CNT_W);
        m_total2 = sat_inc(m_total2, SAT_W);
        if (is_special(in_data)) begin
          m_special  = sat_inc(m_special, CNT_W);
          m_special2 = sat_inc(m_special2, SAT_W);
        end
      end
      m_en = 1'b1;
      m_pushed = pu;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_en && mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("level", 32'(level), 32'(mq.size()));
    chk("total_cnt", 32'(total_cnt), 32'(m_total));
    chk("special_cnt", 32'(special_cnt), 32'(m_special));
    chk("sat_total_cnt", 32'(s_total_cnt), 32'(m_total2));
    chk("sat_special_cnt", 32'(s_special_cnt), 32'(m_special2));
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0]);
      chk("out_flags", 32'({out_sign, out_zero, out_denorm, out_inf, out_nan}), 32'(flags_of(mq[0])));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_pushed) break;
    end
    if (!m_pushed) chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:0] = 31'h0;
      1: begin r[30:23] = 8'h00; if (r[22:0] == 0) r[0] = 1'b1; end
      2: begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
      3: begin r[30:23] = 8'hFF; if (r[22:0] == 0) r[5] = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] words [5];
  logic [4:0]  exp_flags [4];

  initial begin
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // single normal product
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h40C00000;
    tick();
    in_valid = 1'b0;
    chk("p6_valid", 32'(out_valid), 32'd1);
    chk("p6_data", out_data, 32'h40C00000);
    chk("p6_flags", 32'({out_sign, out_zero, out_denorm, out_inf, out_nan}), 32'd0);
    chk("p6_total", 32'(total_cnt), 32'd1);
    chk("p6_special", 32'(special_cnt), 32'd0);
    tick();

    // classification
    out_ready = 1'b0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    words[0] = 32'h80000000; exp_flags[0] = 5'b11000;
    words[1] = 32'h00000001; exp_flags[1] = 5'b00100;
    words[2] = 32'hFF800000; exp_flags[2] = 5'b10010;
    words[3] = 32'h7FC00000; exp_flags[3] = 5'b00001;
    for (int i = 0; i < 4; i++) push_hold(words[i]);
    chk("cls_total", 32'(total_cnt), 32'd4);
    chk("cls_special", 32'(special_cnt), 32'd2);
    chk("cls_sat_total", 32'(s_total_cnt), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("cls_data", out_data, words[i]);
      chk("cls_flags", 32'({out_sign, out_zero, out_denorm, out_inf, out_nan}), 32'(exp_flags[i]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // full, held fifth word, wrap
    for (int i = 0; i < 5; i++) words[i] = 32'h3F800000 + 32'(i * 3);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = words[i];
      tick();
    end
    in_data = words[4];
    tick();
    tick();
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_pop_in_ready", 32'(in_ready), 32'd1);
    chk("after_pop_level", 32'(level), 32'd3);
    tick();
    in_valid = 1'b0;
    chk("refill_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("wrap_order", out_data, words[i]);
      tick();
    end
    out_ready = 1'b0;

    // simultaneous push and pop at level 2
    push_hold(32'h41000000);
    push_hold(32'h41100000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'h42000000 + 32'(i << 16);
      tick();
      chk("steady_level", 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;

    // counter saturation and clear priority
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_hold(32'h7F800000);
    chk("sat_total", 32'(s_total_cnt), 32'd3);
    chk("sat_special", 32'(s_special_cnt), 32'd3);
    chk("wide_total", 32'(total_cnt), 32'd5);
    in_valid = 1'b1;
    in_data  = 32'h7F800000;
    clr_cnt  = 1'b1;
    tick();
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    chk("clr_total", 32'(total_cnt), 32'd0);
    chk("clr_special", 32'(special_cnt), 32'd0);
    chk("clr_sat_total", 32'(s_total_cnt), 32'd0);
    chk("clr_keeps_entry", 32'(level), 32'd1);
    repeat (2) tick();
    out_ready = 1'b0;

    // reset mid-stream
    for (int i = 0; i < 3; i++) push_hold(32'hC0000000 + 32'(i));
    chk("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    chk("rel2_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("rel2_in_ready_high", 32'(in_ready), 32'd1);
    chk("rel2_no_stale", 32'(out_valid), 32'd0);
    push_hold(32'h3F000000);
    chk("rel2_data", out_data, 32'h3F000000);
    chk("rel2_level", 32'(level), 32'd1);

    // randomized traffic with upstream holding until accepted
    in_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || m_pushed) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rand_word();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
